// File: rtl/i2c_util_pkg.sv
// Shared I2C target types: FSM state encoding and ACK/NACK bit levels.
// Latency: n/a (types only); backpressure: n/a.
package i2c_util;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        IGNORE,
        ACK_ADDR,
        REG,
        WDATA,
        ACK_DATA,
        RDATA,
        MACK
    } i2c_target_state_t;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchroniser plus glitch filter: a new level is accepted after FilterLen equal samples.
// Latency: 2 + FilterLen clk; backpressure: none.
module i2c_line_filter #(
    parameter int FilterLen = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level
);

    logic [1:0] sync;
    logic [3:0] cnt;

    // The idle bus level is high, so everything resets to 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync  <= 2'b11;
            cnt   <= '0;
            level <= 1'b1;
        end else begin
            sync <= {sync[0], raw};
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == 4'(FilterLen - 1)) begin
                level <= sync[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/si570_i2c_target.sv
// Si570-style I2C register target: START/STOP decode, address match, 8-bit pointer, strobe bus.
// Latency: ~6 clk pin-to-event; backpressure: none (no clock stretching, reg_rdata 1 clk after reg_re).
module si570_i2c_target
    import i2c_util::*;
#(
    parameter logic [6:0] I2CAddress    = 7'h55,
    parameter int         FilterLen     = 3,
    parameter bit         AutoIncrement = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_o,
    output logic       sda_t,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    i2c_target_state_t state, state_nxt;

    logic       scl_f, sda_f, scl_d, sda_d;
    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [3:0] cnt, cnt_nxt;
    logic [7:0] sr, sr_nxt, ptr, ptr_nxt, wdata_nxt, byte_in;
    logic       sda_rel, rel_nxt, we_nxt, re_nxt, re_d, busy_nxt;
    logic       rw, rw_nxt, mack_ok, mack_ok_nxt;

    i2c_line_filter #(.FilterLen(FilterLen)) u_scl_filter (
        .clk   (clk),
        .reset (reset),
        .raw   (scl_i),
        .level (scl_f)
    );

    i2c_line_filter #(.FilterLen(FilterLen)) u_sda_filter (
        .clk   (clk),
        .reset (reset),
        .raw   (sda_i),
        .level (sda_f)
    );

    assign scl_rise  = scl_f & ~scl_d;
    assign scl_fall  = ~scl_f & scl_d;
    assign start_det = scl_f & sda_d & ~sda_f;
    assign stop_det  = scl_f & ~sda_d & sda_f;
    assign byte_in   = {sr[6:0], sda_f};

    assign sda_o    = 1'b0;
    assign sda_t    = sda_rel;
    assign reg_addr = ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            scl_d     <= 1'b1;
            sda_d     <= 1'b1;
            cnt       <= '0;
            sr        <= '0;
            ptr       <= '0;
            reg_wdata <= '0;
            sda_rel   <= 1'b1;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            re_d      <= 1'b0;
            busy      <= 1'b0;
            rw        <= 1'b0;
            mack_ok   <= 1'b0;
        end else begin
            state     <= state_nxt;
            scl_d     <= scl_f;
            sda_d     <= sda_f;
            cnt       <= cnt_nxt;
            sr        <= sr_nxt;
            ptr       <= ptr_nxt;
            reg_wdata <= wdata_nxt;
            sda_rel   <= rel_nxt;
            reg_we    <= we_nxt;
            reg_re    <= re_nxt;
            re_d      <= reg_re;
            busy      <= busy_nxt;
            rw        <= rw_nxt;
            mack_ok   <= mack_ok_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        sr_nxt      = sr;
        ptr_nxt     = ptr;
        wdata_nxt   = reg_wdata;
        rel_nxt     = sda_rel;
        we_nxt      = 1'b0;
        re_nxt      = 1'b0;
        busy_nxt    = busy;
        rw_nxt      = rw;
        mack_ok_nxt = mack_ok;

        // Pointer post-increments the cycle after each strobe, so the strobe sees the old address.
        if (reg_we || reg_re) ptr_nxt = ptr + {7'd0, AutoIncrement};
        if (re_d) sr_nxt = reg_rdata;

        if (start_det) begin
            state_nxt = ADDR;
            cnt_nxt   = '0;
            rel_nxt   = 1'b1;
            busy_nxt  = 1'b0;
        end else if (stop_det) begin
            state_nxt = IDLE;
            rel_nxt   = 1'b1;
            busy_nxt  = 1'b0;
        end else begin
            case (state)
                ADDR: begin
                    if (scl_rise) begin
                        sr_nxt  = byte_in;
                        cnt_nxt = cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            rw_nxt    = sda_f;
                            state_nxt = (byte_in[7:1] == I2CAddress) ? ACK_ADDR : IGNORE;
                        end
                    end
                end
                // First fall starts the ACK, second fall ends it; sda_rel tells the two apart.
                ACK_ADDR: begin
                    if (scl_fall) begin
                        if (sda_rel) begin
                            rel_nxt  = I2C_ACK;
                            busy_nxt = 1'b1;
                        end else if (rw) begin
                            state_nxt = RDATA;
                            cnt_nxt   = '0;
                            rel_nxt   = sr[7];
                        end else begin
                            state_nxt = REG;
                            cnt_nxt   = '0;
                            rel_nxt   = 1'b1;
                        end
                    end else if (scl_rise && rw && !sda_rel) begin
                        re_nxt = 1'b1;
                    end
                end
                REG, WDATA: begin
                    if (scl_rise) begin
                        sr_nxt  = byte_in;
                        cnt_nxt = cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            state_nxt = ACK_DATA;
                            if (state == REG) begin
                                ptr_nxt = byte_in;
                            end else begin
                                wdata_nxt = byte_in;
                                we_nxt    = 1'b1;
                            end
                        end
                    end
                end
                ACK_DATA: begin
                    if (scl_fall) begin
                        if (sda_rel) begin
                            rel_nxt = I2C_ACK;
                        end else begin
                            state_nxt = WDATA;
                            cnt_nxt   = '0;
                            rel_nxt   = 1'b1;
                        end
                    end
                end
                RDATA: begin
                    if (scl_rise) begin
                        cnt_nxt = cnt + 4'd1;
                    end else if (scl_fall) begin
                        if (cnt == 4'd8) begin
                            state_nxt   = MACK;
                            rel_nxt     = 1'b1;
                            mack_ok_nxt = 1'b0;
                        end else begin
                            sr_nxt  = {sr[6:0], 1'b0};
                            rel_nxt = sr[6];
                        end
                    end
                end
                MACK: begin
                    if (scl_rise) begin
                        if (sda_f == I2C_ACK) begin
                            re_nxt      = 1'b1;
                            mack_ok_nxt = 1'b1;
                        end else begin
                            state_nxt = IGNORE;
                        end
                    end else if (scl_fall && mack_ok) begin
                        state_nxt = RDATA;
                        cnt_nxt   = '0;
                        rel_nxt   = sr[7];
                    end
                end
                IDLE, IGNORE: ;
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_si570_i2c_target.sv
// Directed bench: bus-level I2C master, register-file model and strobe monitors around si570_i2c_target.
// Latency: n/a; backpressure: n/a.
module tb_si570_i2c_target;

    localparam int Q = 31;  // quarter SCL period in 20 ns clocks, roughly 400 kHz

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       m_scl = 1'b1, m_sda = 1'b1, scl_glitch = 1'b0, sda_glitch = 1'b0;
    logic       scl_line, sda_line;
    logic       sda_o, sda_t, reg_we, reg_re, busy;
    logic [7:0] reg_addr, reg_wdata, reg_rdata;
    logic [7:0] mem [256];
    logic [7:0] exp_rd [6] = '{8'h01, 8'hC2, 8'hBC, 8'h01, 8'h1E, 8'hB8};

    int checks = 0, errors = 0;
    int we_cnt = 0, re_cnt = 0, both_cnt = 0, low_cnt = 0, busy_cnt = 0;
    logic [7:0] we_a [$];
    logic [7:0] we_d [$];

    always #10 clk = ~clk;

    assign scl_line = m_scl & ~scl_glitch;
    assign sda_line = m_sda & (sda_t | sda_o) & ~sda_glitch;

    si570_i2c_target #(.I2CAddress(7'h55), .FilterLen(3), .AutoIncrement(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .scl_i     (scl_line),
        .sda_i     (sda_line),
        .sda_o     (sda_o),
        .sda_t     (sda_t),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .busy      (busy)
    );

    always @(posedge clk) begin
        if (reg_we) mem[reg_addr] <= reg_wdata;
        if (reg_re) reg_rdata <= mem[reg_addr];
    end

    always @(negedge clk) begin
        if (reg_we) begin
            we_cnt++;
            we_a.push_back(reg_addr);
            we_d.push_back(reg_wdata);
        end
        if (reg_re) re_cnt++;
        if (reg_we && reg_re) both_cnt++;
        if (!sda_t) low_cnt++;
        if (busy) busy_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] wa(input int i);
        return (i < we_a.size()) ? 32'(we_a[i]) : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] wd(input int i);
        return (i < we_d.size()) ? 32'(we_d[i]) : 32'hFFFF_FFFF;
    endfunction

    task automatic wt(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        m_sda = 1'b1; wt(Q);
        m_scl = 1'b1; wt(Q);
        m_sda = 1'b0; wt(Q);
        m_scl = 1'b0; wt(Q);
    endtask

    task automatic bus_stop();
        m_sda = 1'b0; wt(Q);
        m_scl = 1'b1; wt(Q);
        m_sda = 1'b1; wt(Q);
    endtask

    task automatic write_bit(input logic b, input logic glitch);
        m_sda = b; wt(Q);
        m_scl = 1'b1; wt(Q);
        if (glitch) begin
            scl_glitch = 1'b1; wt(1); scl_glitch = 1'b0; wt(4);
            sda_glitch = 1'b1; wt(1); sda_glitch = 1'b0;
        end
        wt(Q);
        m_scl = 1'b0; wt(Q);
    endtask

    task automatic read_bit(output logic b);
        m_sda = 1'b1; wt(Q);
        m_scl = 1'b1; wt(Q);
        b = sda_line; wt(Q);
        m_scl = 1'b0; wt(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, input logic glitch, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i], glitch);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic nack);
        logic b;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            read_bit(b);
            d = {d[6:0], b};
        end
        write_bit(nack, 1'b0);
    endtask

    initial begin
        logic       ack, b;
        logic [7:0] d;
        int         b_we, b_re, b_low, b_busy;

        wt(5);
        check_eq("rst_sda_t", sda_t, 1);
        check_eq("rst_sda_o", sda_o, 0);
        check_eq("rst_we_re", {reg_we, reg_re}, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_addr_wdata", {reg_addr, reg_wdata}, 0);
        reset = 1'b0;
        wt(5);

        // single register write
        b_we = we_cnt;
        bus_start();
        write_byte(8'hAA, 1'b0, ack); check_eq("t1_addr_ack", ack, 0);
        check_eq("t1_busy", busy, 1);
        write_byte(8'd135, 1'b0, ack); check_eq("t1_reg_ack", ack, 0);
        write_byte(8'h01, 1'b0, ack); check_eq("t1_dat_ack", ack, 0);
        bus_stop();
        check_eq("t1_we_cnt", we_cnt - b_we, 1);
        check_eq("t1_we_addr", wa(b_we), 135);
        check_eq("t1_we_data", wd(b_we), 8'h01);
        check_eq("t1_busy_after_stop", busy, 0);

        // preload 7..12 by burst write, then pointer write + repeated START + 6-byte read
        b_we = we_cnt;
        bus_start();
        write_byte(8'hAA, 1'b0, ack); check_eq("t2_pre_addr_ack", ack, 0);
        write_byte(8'h07, 1'b0, ack); check_eq("t2_pre_reg_ack", ack, 0);
        for (int i = 0; i < 6; i++) begin
            write_byte(exp_rd[i], 1'b0, ack);
            check_eq($sformatf("t2_pre_ack%0d", i), ack, 0);
        end
        bus_stop();
        check_eq("t2_pre_we_cnt", we_cnt - b_we, 6);
        check_eq("t2_pre_last_addr", wa(b_we + 5), 12);
        check_eq("t2_pre_ptr", reg_addr, 13);
        b_re = re_cnt;
        bus_start();
        write_byte(8'hAA, 1'b0, ack); check_eq("t2_addr_ack", ack, 0);
        write_byte(8'h07, 1'b0, ack); check_eq("t2_reg_ack", ack, 0);
        bus_start();
        write_byte(8'hAB, 1'b0, ack); check_eq("t2_raddr_ack", ack, 0);
        for (int i = 0; i < 6; i++) begin
            read_byte(d, i == 5);
            check_eq($sformatf("t2_rd%0d", i), d, exp_rd[i]);
        end
        bus_stop();
        check_eq("t2_re_cnt", re_cnt - b_re, 6);
        check_eq("t2_ptr", reg_addr, 13);

        // wrong address: NACK and fully silent
        b_we = we_cnt; b_re = re_cnt; b_low = low_cnt; b_busy = busy_cnt;
        bus_start();
        write_byte(8'hAC, 1'b0, ack); check_eq("t3_nack", ack, 1);
        bus_stop();
        check_eq("t3_no_we", we_cnt - b_we, 0);
        check_eq("t3_no_re", re_cnt - b_re, 0);
        check_eq("t3_sda_released", low_cnt - b_low, 0);
        check_eq("t3_no_busy", busy_cnt - b_busy, 0);

        // pointer wrap 255 -> 0
        b_we = we_cnt;
        bus_start();
        write_byte(8'hAA, 1'b0, ack); check_eq("t4_addr_ack", ack, 0);
        write_byte(8'hFF, 1'b0, ack); check_eq("t4_reg_ack", ack, 0);
        write_byte(8'hAA, 1'b0, ack); check_eq("t4_d0_ack", ack, 0);
        write_byte(8'hBB, 1'b0, ack); check_eq("t4_d1_ack", ack, 0);
        bus_stop();
        check_eq("t4_we_cnt", we_cnt - b_we, 2);
        check_eq("t4_we0", {wa(b_we), wd(b_we)}, {32'd255, 32'hAA});
        check_eq("t4_we1", {wa(b_we + 1), wd(b_we + 1)}, {32'd0, 32'hBB});
        check_eq("t4_ptr", reg_addr, 1);

        // single-cycle glitches on SCL and SDA while SCL is high during the data byte
        b_we = we_cnt;
        bus_start();
        write_byte(8'hAA, 1'b0, ack); check_eq("t5_addr_ack", ack, 0);
        write_byte(8'h40, 1'b0, ack); check_eq("t5_reg_ack", ack, 0);
        write_byte(8'h3C, 1'b1, ack); check_eq("t5_dat_ack", ack, 0);
        bus_stop();
        check_eq("t5_we_cnt", we_cnt - b_we, 1);
        check_eq("t5_we", {wa(b_we), wd(b_we)}, {32'h40, 32'h3C});

        // reset while the target drives read bit 0 (mem[8] = 0xC2, bit 0 low)
        bus_start();
        write_byte(8'hAA, 1'b0, ack); check_eq("t6_addr_ack", ack, 0);
        write_byte(8'h08, 1'b0, ack); check_eq("t6_reg_ack", ack, 0);
        bus_start();
        write_byte(8'hAB, 1'b0, ack); check_eq("t6_raddr_ack", ack, 0);
        d = '0;
        for (int i = 0; i < 7; i++) begin
            read_bit(b);
            d = {d[6:0], b};
        end
        check_eq("t6_bits7_1", d, 8'h61);
        check_eq("t6_drive_bit0", sda_t, 0);
        reset = 1'b1;
        #1;
        check_eq("t6_rst_release", sda_t, 1);
        m_scl = 1'b1;
        wt(5);
        reset = 1'b0;
        wt(5);
        check_eq("t6_ptr_cleared", reg_addr, 0);
        b_we = we_cnt;
        bus_start();
        write_byte(8'hAA, 1'b0, ack); check_eq("t6_w_addr_ack", ack, 0);
        write_byte(8'h30, 1'b0, ack); check_eq("t6_w_reg_ack", ack, 0);
        write_byte(8'h5A, 1'b0, ack); check_eq("t6_w_dat_ack", ack, 0);
        bus_stop();
        check_eq("t6_we", {wa(b_we), wd(b_we)}, {32'h30, 32'h5A});
        check_eq("t6_we_cnt", we_cnt - b_we, 1);

        check_eq("never_we_and_re", both_cnt, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
